// File: rtl/disp_mux_cw_if.sv
// Tail-light display bus: sweep/brake requests in, digit enables, segments and end-of-sweep pulse out.
interface disp_mux_cw_if;
  logic       en;
  logic       brake;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       cycle_done;

  modport master (output en, brake, input an, sseg, cycle_done);
  modport slave  (input en, brake, output an, sseg, cycle_done);
endinterface

// File: rtl/disp_mux_cw.sv
// Clockwise tail-light sweep: lights an[3] toward an[0], TICK_DIV clocks per step, then a blank step.
// All outputs registered from next-state, so they change on the same edge as the state.
module disp_mux_cw #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter logic [7:0]  SEG_ON   = 8'b11000110
) (
  input  logic         clk,
  input  logic         reset,
  disp_mux_cw_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    S4    = 3'd4,
    BLANK = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (pre_q == LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    an_d    = 4'b1111;
    sseg_d  = 8'hFF;

    // Priority: en=0 aborts, then brake freezes, then the prescaler advances.
    if (!bus.en) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (!bus.brake) begin
      if (state_q == IDLE) begin
        state_d = S1;
        pre_d   = '0;
      end else if (tick) begin
        pre_d  = '0;
        done_d = (state_q == S4);
        unique case (state_q)
          S1:      state_d = S2;
          S2:      state_d = S3;
          S3:      state_d = S4;
          S4:      state_d = BLANK;
          default: state_d = S1;
        endcase
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (bus.brake) begin
      an_d = 4'b0000;
    end else begin
      unique case (state_d)
        S1:      an_d = 4'b0111;
        S2:      an_d = 4'b0011;
        S3:      an_d = 4'b0001;
        S4:      an_d = 4'b0000;
        default: an_d = 4'b1111;
      endcase
    end

    if (an_d != 4'b1111) sseg_d = SEG_ON;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      an_q    <= 4'b1111;
      sseg_q  <= 8'hFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      done_q  <= done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_disp_mux_cw.sv
// Directed and random checks of disp_mux_cw against a sweep-position reference model.
module tb_disp_mux_cw;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_mux_cw_if dif();

  disp_mux_cw #(.TICK_DIV(T), .SEG_ON(8'hC6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int checks = 0;
  int passes = 0;
  // Position within one 5*T-clock sweep period; -1 means idle.
  int pos    = -1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic b);
    int         prev;
    int         step;
    logic [3:0] full;
    logic [3:0] ea;
    logic [7:0] es;
    logic       ecd;
    reset     = r;
    dif.en    = e;
    dif.brake = b;
    @(posedge clk);
    prev = pos;
    if (r || !e)    pos = -1;
    else if (b)     pos = pos;
    else if (pos < 0) pos = 0;
    else            pos = (pos + 1) % (5 * T);

    full = 4'hF;
    if (r)            ea = 4'hF;
    else if (b)       ea = 4'h0;
    else if (pos < 0) ea = 4'hF;
    else begin
      step = pos / T;
      ea = (step < 4) ? 4'(full >> (step + 1)) : 4'hF;
    end
    es  = (ea == 4'hF) ? 8'hFF : 8'hC6;
    ecd = !r && e && !b && (prev == 4 * T - 1);

    #1;
    chk("an", {4'h0, dif.an}, {4'h0, ea});
    chk("sseg", dif.sseg, es);
    chk("cycle_done", {7'h0, dif.cycle_done}, {7'h0, ecd});
  endtask

  initial begin
    reset     = 1'b1;
    dif.en    = 1'b0;
    dif.brake = 1'b0;

    // reset then idle
    repeat (2)  cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);

    // full sweep plus the restart into S1
    repeat (21) cyc(0, 1, 0);

    // abort in S3, then restart with a full first step
    cyc(1, 0, 0);
    repeat (10) cyc(0, 1, 0);
    cyc(0, 0, 0);
    repeat (6) cyc(0, 1, 0);

    // brake in S2 with prescaler at 1, then resume
    cyc(1, 0, 0);
    repeat (6)  cyc(0, 1, 0);
    repeat (10) cyc(0, 1, 1);
    repeat (4)  cyc(0, 1, 0);

    // reset in S4 overriding en and brake
    cyc(1, 0, 0);
    repeat (13) cyc(0, 1, 0);
    repeat (2)  cyc(1, 1, 1);
    repeat (2)  cyc(0, 1, 0);

    // en=0 with brake: idle but all digits on; brake from idle holds idle
    repeat (3) cyc(0, 0, 1);
    repeat (3) cyc(0, 1, 1);
    repeat (3) cyc(0, 1, 0);

    // random mix
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) != 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/disp_mux_cw.md
Name: disp_mux_cw

Overview:
- Clockwise (right-turn) companion to the counter-clockwise tail-light display sequencer. It lights the four 7-segment digits one after another from the leftmost digit (an[3]) toward the rightmost digit (an[0]).
- Each step lasts a parameterised number of clocks. After a full sweep there is a blanked step, then the sweep repeats.
- Sits beside the counter-clockwise sequencer in the tail-light top level. It adds brake override and an end-of-sweep pulse for the system controller.

Parameters:
- TICK_DIV, 25_000_000: clocks per sequence step (0.25 s at 100 MHz). Must be >= 2.
- SEG_ON, 8'b11000110: active-low segment pattern driven while any digit is lit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  turn-signal request; high runs the sweep, low returns to idle.
- brake  input  1  brake request; overrides the sweep with all digits lit, steady.
- an  output  4  active-low digit enables, registered.
- sseg  output  8  active-low segments, registered.
- cycle_done  output  1  one-clock pulse at the end of each full sweep, registered.

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - state=IDLE, prescaler=0.
  - an=4'b1111, sseg=8'hFF, cycle_done=0.
  - Reset overrides en and brake. Asserting reset mid-sweep aborts the sweep on that edge.
- States and the an value each drives:
  - IDLE: 1111
  - S1: 0111
  - S2: 0011
  - S3: 0001
  - S4: 0000
  - BLANK: 1111
- sseg=SEG_ON whenever the registered an != 1111, else 8'hFF.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - Counts 0..TICK_DIV-1 while state != IDLE, en=1 and brake=0.
  - tick = (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
  - Cleared to 0 in IDLE.
- Transitions:
  - IDLE: en=1 and brake=0 -> S1 (prescaler=0).
  - S1->S2->S3->S4->BLANK->S1, each on tick. Every step lasts exactly TICK_DIV clocks.
  - en=0 in any state (brake=0 or 1) -> IDLE on the next edge; prescaler cleared.
- Brake:
  - brake=1 freezes state and prescaler.
  - Next-edge outputs: an=0000, sseg=SEG_ON, cycle_done=0.
  - On brake release, the sweep resumes from the frozen state and count.
  - brake=1 with en=0: state goes to IDLE, outputs still all-on.
- Latency:
  - Outputs are registered from the next-state and next-brake values, so they change on the same edge as the state.
  - en rising at edge k: S1 and an=0111 at edge k+1.
- cycle_done:
  - High for exactly the one clock after the S4->BLANK transition edge.
  - Never asserted on abort, in IDLE, or under brake.
- Simultaneous events: priority is reset > en=0 > brake > tick.

Test Plan:
- Reset then idle: reset=1 for 2 clks with en=0 -> an=1111, sseg=FF, cycle_done=0; held for 20 clks.
- Full sweep (TICK_DIV=4): en=1 from edge 0 -> an reads, 4 clocks each:
  - edges 1-4: 0111
  - edges 5-8: 0011
  - edges 9-12: 0001
  - edges 13-16: 0000
  - edges 17-20: 1111, with cycle_done=1 only after edge 17
  - edge 21: 0111 again
  - sseg=C6 whenever lit, FF when blank.
- Abort: drop en during S3 -> next edge an=1111, sseg=FF, no cycle_done. Re-raise en -> sweep restarts at S1 with a full 4-clock step.
- Brake mid-step: in S2 with prescaler=1, hold brake 10 clks -> an=0000, sseg=C6. After release, an=0011 for the remaining 2 clks, then S3.
- Reset mid-sweep and priority:
  - Reset in S4 with en=1 and brake=1 -> next edge IDLE outputs; S1 on the edge after reset deasserts.
  - en=0 with brake=1 -> IDLE state with an=0000.
